morse_lcd_writer: RTL and testbench

//  Downstream stage of the Morse decoder. Takes decoded 8-bit ASCII characters and drives an
//  HD44780-compatible 16x2 character LCD in 8-bit write-only mode.

---
 rtl/morse_lcd_pkg.sv | 53 +++++
 rtl/lcd_bus_cycle.sv | 121 ++++++++++++
 rtl/morse_lcd_writer.sv | 185 ++++++++++++++++++
 tb/tb_morse_lcd_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_lcd_pkg.sv
// morse_lcd_pkg
//   Shared definitions for the Morse decoder LCD writer:
//   - HD44780 command bytes used by the init sequence and the cursor logic
//   - top-level and bus-cycle FSM state encodings
//   - lcd_cmd_t: one LCD bus write (register select + data byte)
//   - helpers for the init command table and clear-command detection
package morse_lcd_pkg;

  // HD44780 commands (8-bit interface)
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON       = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] CLEAR         = 8'h01;  // clear display, home cursor
  localparam logic [7:0] ENTRY_INC     = 8'h06;  // increment address, no shift
  localparam logic [7:0] LINE1         = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LINE2         = 8'hC0;  // DDRAM address 0x40

  // Top-level FSM
  localparam logic [2:0] ST_PWRUP  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_CYCLE  = 3'd3;
  localparam logic [2:0] ST_CURSOR = 3'd4;

  // Bus-cycle FSM
  localparam logic [1:0] BUS_IDLE  = 2'd0;
  localparam logic [1:0] BUS_SETUP = 2'd1;
  localparam logic [1:0] BUS_EN_HI = 2'd2;
  localparam logic [1:0] BUS_WAIT  = 2'd3;

  typedef struct packed {
    logic       rs;    // 0 = command, 1 = data
    logic [7:0] data;
  } lcd_cmd_t;

  // Power-up init sequence, issued in index order 0..3.
  function automatic lcd_cmd_t init_cmd(input logic [1:0] idx);
    lcd_cmd_t c;
    c.rs = 1'b0;
    case (idx)
      2'd0:    c.data = FUNC_SET_8B2L;
      2'd1:    c.data = DISP_ON;
      2'd2:    c.data = CLEAR;
      default: c.data = ENTRY_INC;
    endcase
    return c;
  endfunction

  // Clear is the only command that needs the long post-strobe wait.
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data == CLEAR);
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle
//   Performs one timed HD44780 write: SETUP -> EN_HI -> WAIT.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     start_i         launch a write (sampled only in BUS_IDLE)
//     cmd_i           rs + data for the write, captured with start_i
//     done_o          high during the last WAIT cycle (combinational)
//     lcd_data_o      DB7..DB0, held from capture until the next capture
//     lcd_rs_o        register select, held like lcd_data_o
//     lcd_en_o        enable strobe, registered
//     state_o         current bus FSM state (debug)
//   All cycle parameters must be >= 1.
module lcd_bus_cycle
  import morse_lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned EN_CYCLES         = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  lcd_cmd_t   cmd_i,
  output logic       done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [1:0] state_o
);

  localparam int unsigned MAX_A   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                                    CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // The counter only ever holds 0..MAX_CYC-1.
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] wait_last;

  // The wait length follows the byte currently on the bus.
  assign wait_last = is_clear_cmd(rs_q, data_q) ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    case (state_q)
      BUS_IDLE: begin
        if (start_i) begin
          data_d  = cmd_i.data;
          rs_d    = cmd_i.rs;
          cnt_d   = '0;
          state_d = BUS_SETUP;
        end
      end
      BUS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = BUS_EN_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUS_EN_HI: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          en_d    = 1'b0;
          state_d = BUS_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin  // BUS_WAIT
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          state_d = BUS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
    end
  end

  // Combinational so the owner can chain the next write without a dead cycle.
  assign done_o     = (state_q == BUS_WAIT) && (cnt_q == wait_last);
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;
  assign state_o    = state_q;

endmodule

// File: rtl/morse_lcd_writer.sv
// morse_lcd_writer
//   Takes decoded ASCII characters and writes them to an HD44780 16x2 LCD in
//   8-bit write-only mode. Runs the power-up init sequence, tracks the cursor
//   column and inserts line-2 / wrap-to-line-1 address commands.
//   Ports:
//     clock, reset_all   clock, asynchronous active-low reset
//     char_in/char_valid/char_ready   character input handshake
//     clear_req          clear display and home cursor (honoured in IDLE only)
//     busy               init or bus cycle in progress
//     lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on   LCD pins
//     dbg_state_o        {bus FSM state, top FSM state}
//
//   Handshake: a character transfers on the rising clock edge where
//   char_valid and char_ready are both 1. char_ready depends only on the FSM
//   state and clear_req, never on char_valid; char_valid while not ready is
//   ignored and each transfer produces exactly one data write.
module morse_lcd_writer
  import morse_lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned EN_CYCLES         = 12,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
  parameter int unsigned COLS              = 16
) (
  input  logic       clock,
  input  logic       reset_all,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic [4:0] dbg_state_o
);

  localparam int unsigned PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int unsigned COL_W = $clog2(2 * COLS + 1);

  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(POWERUP_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_L1END = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_L2    = COL_W'(COLS);
  localparam logic [COL_W-1:0] COL_L2END = COL_W'(2 * COLS - 1);

  logic [2:0]       state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             start_q, start_d;
  lcd_cmd_t         cmd_q, cmd_d;
  logic             clr_q, clr_d;   // current CYCLE is a user clear, not a char

  logic             bus_done;
  logic [1:0]       bus_state;

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    init_idx_d = init_idx_q;
    col_d      = col_q;
    start_d    = 1'b0;
    cmd_d      = cmd_q;
    clr_d      = clr_q;
    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          init_idx_d = 2'd0;
          cmd_d      = init_cmd(2'd0);
          start_d    = 1'b1;
          state_d    = ST_INIT;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end
      end
      ST_INIT: begin
        if (bus_done) begin
          if (init_idx_q == 2'd3) begin
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            cmd_d      = init_cmd(init_idx_q + 2'd1);
            start_d    = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        // clear_req wins over a character presented in the same cycle.
        if (clear_req) begin
          cmd_d   = '{rs: 1'b0, data: CLEAR};
          clr_d   = 1'b1;
          start_d = 1'b1;
          state_d = ST_CYCLE;
        end else if (char_valid) begin
          cmd_d   = '{rs: 1'b1, data: char_in};
          clr_d   = 1'b0;
          start_d = 1'b1;
          state_d = ST_CYCLE;
        end
      end
      ST_CYCLE: begin
        if (bus_done) begin
          if (clr_q) begin
            col_d   = '0;
            state_d = ST_IDLE;
          end else if (col_q == COL_L1END) begin
            // End of line 1: move the LCD address to the start of line 2.
            col_d   = COL_L2;
            cmd_d   = '{rs: 1'b0, data: LINE2};
            start_d = 1'b1;
            state_d = ST_CURSOR;
          end else if (col_q == COL_L2END) begin
            // End of line 2: wrap to line 1 and overwrite.
            col_d   = '0;
            cmd_d   = '{rs: 1'b0, data: LINE1};
            start_d = 1'b1;
            state_d = ST_CURSOR;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      ST_CURSOR: begin
        if (bus_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_all) begin
    if (!reset_all) begin
      state_q    <= ST_PWRUP;
      pwr_cnt_q  <= '0;
      init_idx_q <= 2'd0;
      col_q      <= '0;
      start_q    <= 1'b0;
      cmd_q      <= '0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      init_idx_q <= init_idx_d;
      col_q      <= col_d;
      start_q    <= start_d;
      cmd_q      <= cmd_d;
      clr_q      <= clr_d;
    end
  end

  // start_q is a one-cycle pulse; the bus cycle captures cmd_q with it, so
  // data appears on the pins one cycle after the handshake edge.
  lcd_bus_cycle #(
    .SETUP_CYCLES      (SETUP_CYCLES),
    .EN_CYCLES         (EN_CYCLES),
    .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
  ) u_bus (
    .clk_i      (clock),
    .rst_ni     (reset_all),
    .start_i    (start_q),
    .cmd_i      (cmd_q),
    .done_o     (bus_done),
    .lcd_data_o (lcd_data),
    .lcd_rs_o   (lcd_rs),
    .lcd_en_o   (lcd_en),
    .state_o    (bus_state)
  );

  assign char_ready  = (state_q == ST_IDLE) && !clear_req;
  assign busy        = (state_q != ST_IDLE);
  assign lcd_rw      = 1'b0;
  assign lcd_on      = 1'b1;
  assign dbg_state_o = {bus_state, state_q};

endmodule

// File: tb/tb_morse_lcd_writer.sv
module tb_morse_lcd_writer;

  localparam int POWERUP    = 20;
  localparam int SETUP      = 2;
  localparam int EN         = 3;
  localparam int CMD_WAIT   = 5;
  localparam int CLEAR_WAIT = 10;
  localparam int COLS       = 4;
  localparam int WR_LAT     = 1 + SETUP + EN + CMD_WAIT;    // accept -> ready again
  localparam int CLR_LAT    = 1 + SETUP + EN + CLEAR_WAIT;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_all;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       clear_req;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic [4:0] dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  morse_lcd_writer #(
    .POWERUP_CYCLES    (POWERUP),
    .SETUP_CYCLES      (SETUP),
    .EN_CYCLES         (EN),
    .CMD_WAIT_CYCLES   (CMD_WAIT),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT),
    .COLS              (COLS)
  ) dut (
    .clock       (clock),
    .reset_all   (reset_all),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .clear_req   (clear_req),
    .busy        (busy),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .lcd_on      (lcd_on),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];        // expected {rs, data} per EN pulse, in order
  int n_checks = 0;
  int n_pass   = 0;
  int model_col = 0;           // reference cursor position 0..2*COLS-1
  int exp_ready_at = -1;       // cycle at which char_ready must come back
  int first_rise = -1;
  int rel_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic model_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    model_col = 0;
    exp_ready_at = -1;
  endtask

  task automatic model_char(input logic [7:0] ch, input int t_acc);
    int lat;
    exp_q.push_back({1'b1, ch});
    lat = WR_LAT;
    model_col = model_col + 1;
    if (model_col == COLS) begin
      exp_q.push_back(9'h0C0);
      lat = lat + WR_LAT;
    end else if (model_col == 2 * COLS) begin
      exp_q.push_back(9'h080);
      model_col = 0;
      lat = lat + WR_LAT;
    end
    exp_ready_at = t_acc + lat;
  endtask

  task automatic model_clear(input int t_acc);
    exp_q.push_back(9'h001);
    model_col = 0;
    exp_ready_at = t_acc + CLR_LAT;
  endtask

  // ---------------- monitor ----------------
  logic       prev_en = 1'b0;
  logic       prev_ready = 1'b0;
  logic [8:0] prev_bus = '0;
  int stable = 0;
  int hi_cnt = 0;
  int last_fall = -1;
  int last_wait = CMD_WAIT;

  always @(negedge clock) begin
    logic [8:0] bus;
    logic [8:0] exp_v;
    bus = {lcd_rs, lcd_data};
    if (!reset_all) begin
      prev_en = 1'b0; prev_ready = 1'b0; prev_bus = '0;
      stable = 0; hi_cnt = 0; last_fall = -1;
    end else begin
      if (bus !== prev_bus) begin
        stable = 1;
        if (last_fall >= 0) check("data_held_through_wait", 32'(cyc - last_fall >= last_wait + 1), 1);
      end else begin
        stable++;
      end
      if (lcd_en && !prev_en) begin
        hi_cnt = 1;
        if (first_rise < 0) first_rise = cyc;
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("bus_write", 32'(bus), 32'(exp_v));
        end
        check("setup_before_en", 32'(stable >= SETUP + 1), 1);
        check("busy_during_write", 32'(busy), 1);
        check("rw_low", 32'(lcd_rw), 0);
        if (last_fall >= 0) check("gap_after_prev_cmd", 32'(cyc - last_fall >= last_wait), 1);
      end else if (lcd_en) begin
        hi_cnt++;
      end
      if (!lcd_en && prev_en) begin
        check("en_width", 32'(hi_cnt), EN);
        last_fall = cyc;
        last_wait = (bus == 9'h001) ? CLEAR_WAIT : CMD_WAIT;
      end
      if (char_ready && !prev_ready) begin
        check("busy_low_when_ready", 32'(busy), 0);
        if (last_fall >= 0) check("ready_after_wait", 32'(cyc - last_fall), 32'(last_wait));
        if (exp_ready_at >= 0) begin
          check("ready_latency", 32'(cyc), 32'(exp_ready_at));
          exp_ready_at = -1;
        end
      end
      prev_en = lcd_en;
      prev_ready = char_ready;
      prev_bus = bus;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!char_ready && k < limit);
    if (!char_ready) check("ready_timeout", 32'(char_ready), 1);
  endtask

  task automatic check_reset_state();
    check("rst_lcd_data", 32'(lcd_data), 0);
    check("rst_lcd_rs", 32'(lcd_rs), 0);
    check("rst_lcd_rw", 32'(lcd_rw), 0);
    check("rst_lcd_en", 32'(lcd_en), 0);
    check("rst_lcd_on", 32'(lcd_on), 1);
    check("rst_busy", 32'(busy), 1);
    check("rst_char_ready", 32'(char_ready), 0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    model_init();
    first_rise = -1;
    rel_cyc = cyc;
    #2 reset_all = 1'b1;
  endtask

  task automatic send_char(input logic [7:0] ch);
    wait_ready(400);
    #1;
    char_in = ch;
    char_valid = 1'b1;
    model_char(ch, cyc + 1);
    @(posedge clock);
    #1 char_valid = 1'b0;
  endtask

  task automatic do_clear(input logic with_char, input logic [7:0] ch);
    wait_ready(400);
    #1;
    clear_req = 1'b1;
    if (with_char) begin
      char_in = ch;
      char_valid = 1'b1;
    end
    #1 check("ready_masked_by_clear", 32'(char_ready), 0);
    model_clear(cyc + 1);
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    char_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic [7:0] ch;
    reset_all = 1'b0;
    char_in = 8'h00;
    char_valid = 1'b0;
    clear_req = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state();

    // Power-up and init sequence
    release_reset();
    wait_ready(300);
    check("powerup_delay", 32'(first_rise - rel_cyc >= POWERUP), 1);

    // Single character
    send_char(8'h41);

    // Two full lines from column 0: line-2 command after 4th, wrap after 8th
    do_clear(1'b0, 8'h00);
    for (int i = 0; i < 2 * COLS; i++) send_char(8'($urandom_range(8'h41, 8'h5A)));
    send_char(8'h61);

    // Clear and char together: clear wins, char dropped
    do_clear(1'b1, 8'h5A);
    send_char(8'h42);

    // Random mix of characters and clears
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 6) == 0) do_clear(1'($urandom_range(0, 1)), 8'($urandom_range(8'h20, 8'h7E)));
      else send_char(8'($urandom_range(8'h20, 8'h7E)));
    end

    // char_valid held high for 40 cycles with a constant char
    ch = 8'($urandom_range(8'h30, 8'h39));
    wait_ready(400);
    #1;
    char_in = ch;
    char_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (char_ready) model_char(ch, cyc + 1);
      @(negedge clock);
      #1;
    end
    char_valid = 1'b0;

    // Reset while EN is high: EN drops at once, init repeats
    send_char(8'h43);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!lcd_en && k < 20);
    check("en_seen_before_reset", 32'(lcd_en), 1);
    #2 reset_all = 1'b0;
    #1 check("en_drops_on_reset", 32'(lcd_en), 0);
    exp_q.delete();
    exp_ready_at = -1;
    check_reset_state();
    repeat (3) @(negedge clock);
    release_reset();
    wait_ready(300);
    check("powerup_delay_after_reset", 32'(first_rise - rel_cyc >= POWERUP), 1);
    send_char(8'h44);
    wait_ready(400);
    repeat (2) @(negedge clock);

    check("queue_drained", 32'(exp_q.size()), 0);
    check("lcd_on_high", 32'(lcd_on), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
